// File: rtl/usb_xact_sched.sv
// usb_xact_sched: host-side USB transaction scheduler.
// Arbitrates two requesters round-robin. Each transaction is sequenced as a
// token, then a data phase, then a handshake. A DATA0/DATA1 toggle is kept per
// requester, and every accepted request produces exactly one completion status.
// Optional feature: define XACT_RETRY_EN to retry a transaction that fails on a
// timeout, a bad PID or a CRC error, up to MAX_RETRY extra attempts. With the
// macro undefined, the first failure is final and reports ERR.

module usb_xact_sched #(
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_kind,
  input  logic [6:0] req0_addr,
  input  logic [3:0] req0_endp,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_kind,
  input  logic [6:0] req1_addr,
  input  logic [3:0] req1_endp,
  output logic [3:0] tx_pid,
  output logic [6:0] tx_addr,
  output logic [3:0] tx_endp,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       dout_start,
  output logic [3:0] dout_pid,
  output logic       dout_id,
  input  logic       tx_lt_valid,
  input  logic       tx_lt_ready,
  input  logic       tx_lt_eop,
  input  logic       rx_pid_en,
  input  logic [3:0] rx_pid,
  input  logic       rx_lt_valid,
  input  logic       rx_lt_ready,
  input  logic       rx_lt_eop,
  input  logic       crc16_err,
  input  logic       time_out,
  output logic       done_valid,
  output logic       done_id,
  output logic [2:0] done_status
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  localparam logic [2:0] ST_ACK   = 3'b000;
  localparam logic [2:0] ST_NAK   = 3'b001;
  localparam logic [2:0] ST_STALL = 3'b010;
  localparam logic [2:0] ST_ERR   = 3'b011;
  localparam logic [2:0] ST_SKIP  = 3'b100;

`ifdef XACT_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  // The retry counter is only 4 bits wide, so a larger MAX_RETRY is clamped to 15.
  localparam logic [3:0] RETRY_LIMIT = (MAX_RETRY > 15) ? 4'd15 : 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOKEN,
    S_DOUT,
    S_WAIT_HS,
    S_WAIT_DATA,
    S_RX_BODY,
    S_SEND_ACK,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic       rr_ptr;
  logic       cur_id;
  logic [1:0] cur_kind;
  logic [6:0] cur_addr;
  logic [3:0] cur_endp;
  logic [1:0] toggle;
  logic [3:0] retry_cnt;
  logic       rx_data1;

  logic       grant;
  logic       grant_id;
  logic       token_acc;
  logic       set_status;
  logic [2:0] status_val;
  logic       flip_toggle;
  logic       failure;
  logic       retry_inc;
  logic       latch_rx;

  logic kind_in;
  logic kind_setup;
  logic cur_toggle;
  logic tx_end;
  logic rx_end;
  logic retry_ok;

  // Reserved kind 11 falls through to OUT handling because it matches neither IN nor SETUP.
  assign kind_in    = (cur_kind == 2'b01);
  assign kind_setup = (cur_kind == 2'b10);
  assign cur_toggle = toggle[cur_id];
  assign tx_end     = tx_lt_valid & tx_lt_ready & tx_lt_eop;
  assign rx_end     = rx_lt_valid & rx_lt_ready & rx_lt_eop;
  // The count stops at the limit, so "not yet at the limit" means "retries remain".
  assign retry_ok   = RETRY_EN && (retry_cnt != RETRY_LIMIT);

  // The token address and endpoint hold their latched values for the whole transaction, including the ACK.
  assign tx_addr = cur_addr;
  assign tx_endp = cur_endp;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, link-facing strobes, and the decision of each transaction's outcome.
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    grant_id    = 1'b0;
    token_acc   = 1'b0;
    set_status  = 1'b0;
    status_val  = ST_ACK;
    flip_toggle = 1'b0;
    failure     = 1'b0;
    retry_inc   = 1'b0;
    latch_rx    = 1'b0;
    tx_valid    = 1'b0;
    tx_pid      = 4'b0000;
    done_valid  = 1'b0;

    case (state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant      = 1'b1;
          grant_id   = rr_ptr ? req1_valid : ~req0_valid;
          state_next = S_TOKEN;
        end
      end

      S_TOKEN: begin
        tx_valid = 1'b1;
        tx_pid   = kind_in ? PID_IN : (kind_setup ? PID_SETUP : PID_OUT);
        if (tx_ready) begin
          token_acc  = 1'b1;
          state_next = kind_in ? S_WAIT_DATA : S_DOUT;
        end
      end

      S_DOUT: begin
        if (tx_end) begin
          state_next = S_WAIT_HS;
        end
      end

      S_WAIT_HS: begin
        if (rx_pid_en) begin
          case (rx_pid)
            PID_ACK: begin
              set_status  = 1'b1;
              status_val  = ST_ACK;
              flip_toggle = 1'b1;
              state_next  = S_DONE;
            end
            PID_NAK: begin
              set_status = 1'b1;
              status_val = ST_NAK;
              state_next = S_DONE;
            end
            PID_STALL: begin
              set_status = 1'b1;
              status_val = ST_STALL;
              state_next = S_DONE;
            end
            default: failure = 1'b1;
          endcase
        end else if (time_out) begin
          failure = 1'b1;
        end
      end

      S_WAIT_DATA: begin
        if (rx_pid_en) begin
          case (rx_pid)
            PID_DATA0, PID_DATA1: begin
              latch_rx   = 1'b1;
              state_next = S_RX_BODY;
            end
            PID_NAK: begin
              set_status = 1'b1;
              status_val = ST_NAK;
              state_next = S_DONE;
            end
            PID_STALL: begin
              set_status = 1'b1;
              status_val = ST_STALL;
              state_next = S_DONE;
            end
            default: failure = 1'b1;
          endcase
        end else if (time_out) begin
          failure = 1'b1;
        end
      end

      S_RX_BODY: begin
        if (rx_end) begin
          if (crc16_err) begin
            failure = 1'b1;
          end else begin
            set_status = 1'b1;
            state_next = S_SEND_ACK;
            if (rx_data1 == cur_toggle) begin
              status_val  = ST_ACK;
              flip_toggle = 1'b1;
            end else begin
              status_val = ST_SKIP;
            end
          end
        end
      end

      S_SEND_ACK: begin
        tx_valid = 1'b1;
        tx_pid   = PID_ACK;
        if (tx_ready) begin
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        done_valid = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase

    if (failure) begin
      if (retry_ok) begin
        retry_inc  = 1'b1;
        state_next = S_TOKEN;
      end else begin
        set_status = 1'b1;
        status_val = ST_ERR;
        state_next = S_DONE;
      end
    end
  end

  // Datapath: grant latching, toggles, retry count, and the registered data-mover and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= 1'b0;
      cur_id      <= 1'b0;
      cur_kind    <= 2'b00;
      cur_addr    <= 7'd0;
      cur_endp    <= 4'd0;
      toggle      <= 2'b00;
      retry_cnt   <= 4'd0;
      rx_data1    <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      dout_start  <= 1'b0;
      dout_pid    <= 4'b0000;
      dout_id     <= 1'b0;
      done_id     <= 1'b0;
      done_status <= 3'b000;
    end else begin
      req0_ready <= grant & ~grant_id;
      req1_ready <= grant & grant_id;
      dout_start <= token_acc & ~kind_in;

      if (grant) begin
        cur_id    <= grant_id;
        cur_kind  <= grant_id ? req1_kind : req0_kind;
        cur_addr  <= grant_id ? req1_addr : req0_addr;
        cur_endp  <= grant_id ? req1_endp : req0_endp;
        retry_cnt <= 4'd0;
        rr_ptr    <= ~grant_id;
      end

      // SETUP clears the toggle at this same edge, so its data phase must use DATA0 directly.
      if (token_acc && !kind_in) begin
        dout_pid <= (kind_setup || !cur_toggle) ? PID_DATA0 : PID_DATA1;
        dout_id  <= cur_id;
      end

      if (token_acc && kind_setup) begin
        toggle[cur_id] <= 1'b0;
      end

      if (flip_toggle) begin
        toggle[cur_id] <= ~cur_toggle;
      end

      if (latch_rx) begin
        rx_data1 <= rx_pid[3];
      end

      if (retry_inc && (retry_cnt != 4'hF)) begin
        retry_cnt <= retry_cnt + 4'd1;
      end

      if (set_status) begin
        done_status <= status_val;
        done_id     <= cur_id;
      end
    end
  end

endmodule

// File: tb/tb_usb_xact_sched.sv
// tb_usb_xact_sched: directed test of usb_xact_sched with a completion scoreboard.
// Expected completions are queued when a request is issued. A monitor pops them as done_valid pulses.
// Follows the XACT_RETRY_EN define so that its expectations match the build.

module tb_usb_xact_sched;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  localparam logic [1:0] K_OUT   = 2'b00;
  localparam logic [1:0] K_IN    = 2'b01;
  localparam logic [1:0] K_SETUP = 2'b10;
  localparam logic [1:0] K_RSVD  = 2'b11;

  localparam logic [2:0] ST_ACK   = 3'b000;
  localparam logic [2:0] ST_NAK   = 3'b001;
  localparam logic [2:0] ST_STALL = 3'b010;
  localparam logic [2:0] ST_ERR   = 3'b011;
  localparam logic [2:0] ST_SKIP  = 3'b100;

`ifdef XACT_RETRY_EN
  localparam int TIMEOUT_ATTEMPTS = 3;
`else
  localparam int TIMEOUT_ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_kind, req1_kind;
  logic [6:0] req0_addr, req1_addr;
  logic [3:0] req0_endp, req1_endp;
  logic [3:0] tx_pid;
  logic [6:0] tx_addr;
  logic [3:0] tx_endp;
  logic       tx_valid, tx_ready;
  logic       dout_start;
  logic [3:0] dout_pid;
  logic       dout_id;
  logic       tx_lt_valid, tx_lt_ready, tx_lt_eop;
  logic       rx_pid_en;
  logic [3:0] rx_pid;
  logic       rx_lt_valid, rx_lt_ready, rx_lt_eop;
  logic       crc16_err, time_out;
  logic       done_valid, done_id;
  logic [2:0] done_status;

  typedef struct packed {
    logic       id;
    logic [2:0] status;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  usb_xact_sched #(.MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_kind(req0_kind),
    .req0_addr(req0_addr), .req0_endp(req0_endp),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_kind(req1_kind),
    .req1_addr(req1_addr), .req1_endp(req1_endp),
    .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dout_start(dout_start), .dout_pid(dout_pid), .dout_id(dout_id),
    .tx_lt_valid(tx_lt_valid), .tx_lt_ready(tx_lt_ready), .tx_lt_eop(tx_lt_eop),
    .rx_pid_en(rx_pid_en), .rx_pid(rx_pid),
    .rx_lt_valid(rx_lt_valid), .rx_lt_ready(rx_lt_ready), .rx_lt_eop(rx_lt_eop),
    .crc16_err(crc16_err), .time_out(time_out),
    .done_valid(done_valid), .done_id(done_id), .done_status(done_status)
  );

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: waited too long, got no response, expected one", name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_tx_valid"}, 8'(tx_valid), 8'd0);
    check_output({tag, "_tx_pid"}, 8'(tx_pid), 8'd0);
    check_output({tag, "_tx_addr"}, 8'(tx_addr), 8'd0);
    check_output({tag, "_tx_endp"}, 8'(tx_endp), 8'd0);
    check_output({tag, "_ready"}, 8'({req1_ready, req0_ready}), 8'd0);
    check_output({tag, "_dout"}, 8'({dout_start, dout_id, dout_pid}), 8'd0);
    check_output({tag, "_done"}, 8'({done_valid, done_id, done_status}), 8'd0);
  endtask

  task automatic post_req(input logic id, input logic [1:0] kind, input logic [6:0] addr, input logic [3:0] endp);
    if (id) begin
      req1_valid = 1'b1; req1_kind = kind; req1_addr = addr; req1_endp = endp;
    end else begin
      req0_valid = 1'b1; req0_kind = kind; req0_addr = addr; req0_endp = endp;
    end
  endtask

  task automatic grant_wait(input logic id, input bit chk_lat);
    int n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(id ? req1_ready : req0_ready)) begin
      fail_timeout("grant_wait");
    end else begin
      if (chk_lat) check_output("ready_latency", 8'(n), 8'd0);
      check_output("other_ready", 8'(id ? req0_ready : req1_ready), 8'd0);
      check_output("tx_valid_with_ready", 8'(tx_valid), 8'd1);
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input logic id, input logic [1:0] kind, input logic [6:0] addr,
                                input logic [3:0] endp, input logic [2:0] status);
    exp_q.push_back('{id: id, status: status});
    post_req(id, kind, addr, endp);
    grant_wait(id, 1'b1);
  endtask

  task automatic accept_tx(input logic [3:0] exp_pid, input string name);
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) begin
      fail_timeout(name);
    end else begin
      check_output(name, 8'(tx_pid), 8'(exp_pid));
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      check_output({name, "_drop"}, 8'(tx_valid), 8'd0);
    end
  endtask

  task automatic send_dout(input logic [3:0] exp_pid, input logic exp_id);
    check_output("dout_start", 8'(dout_start), 8'd1);
    check_output("dout_pid", 8'(dout_pid), 8'(exp_pid));
    check_output("dout_id", 8'(dout_id), 8'(exp_id));
    tx_lt_valid = 1'b1; tx_lt_ready = 1'b1; tx_lt_eop = 1'b1;
    @(negedge clk);
    tx_lt_valid = 1'b0; tx_lt_ready = 1'b0; tx_lt_eop = 1'b0;
    check_output("dout_start_pulse", 8'(dout_start), 8'd0);
  endtask

  task automatic send_pid(input logic [3:0] pid, input logic to, input bit chk_done);
    rx_pid_en = 1'b1; rx_pid = pid; time_out = to;
    @(negedge clk);
    rx_pid_en = 1'b0; rx_pid = 4'd0; time_out = 1'b0;
    if (chk_done) check_output("done_latency", 8'(done_valid), 8'd1);
  endtask

  task automatic send_timeout();
    time_out = 1'b1;
    @(negedge clk);
    time_out = 1'b0;
  endtask

  task automatic rx_finish(input logic crc);
    rx_lt_valid = 1'b1; rx_lt_ready = 1'b1; rx_lt_eop = 1'b1; crc16_err = crc;
    @(negedge clk);
    rx_lt_valid = 1'b0; rx_lt_ready = 1'b0; rx_lt_eop = 1'b0; crc16_err = 1'b0;
  endtask

  task automatic quiet(input int cycles, input string name);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx_valid) seen++;
    end
    check_output(name, 8'(seen), 8'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_timeout("wait_drain");
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_kind = 2'b00; req0_addr = 7'd0; req0_endp = 4'd0;
    req1_valid = 1'b0; req1_kind = 2'b00; req1_addr = 7'd0; req1_endp = 4'd0;
    tx_ready = 1'b0;
    tx_lt_valid = 1'b0; tx_lt_ready = 1'b0; tx_lt_eop = 1'b0;
    rx_pid_en = 1'b0; rx_pid = 4'd0;
    rx_lt_valid = 1'b0; rx_lt_ready = 1'b0; rx_lt_eop = 1'b0;
    crc16_err = 1'b0; time_out = 1'b0;

    fork
      // Completion monitor: every done_valid pulse must match the oldest queued expectation.
      forever begin
        @(negedge clk);
        if (done_valid) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_done", 8'd1, 8'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check_output("done_id", 8'(done_id), 8'(mon_e.id));
            check_output("done_status", 8'(done_status), 8'(mon_e.status));
          end
        end
      end
      begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    $display("[TB] reset and simultaneous requests");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    exp_q.push_back('{id: 1'b0, status: ST_ACK});
    exp_q.push_back('{id: 1'b1, status: ST_ACK});
    rst = 1'b0;
    post_req(1'b0, K_OUT, 7'h08, 4'd1);
    post_req(1'b1, K_IN, 7'h08, 4'd2);
    grant_wait(1'b0, 1'b1);
    check_output("t1_tx_addr", 8'(tx_addr), 8'h08);
    check_output("t1_tx_endp", 8'(tx_endp), 8'd1);
    accept_tx(PID_OUT, "t1_out_token");
    send_dout(PID_DATA0, 1'b0);
    send_pid(PID_ACK, 1'b0, 1'b1);
    grant_wait(1'b1, 1'b0);
    check_output("t1_in_endp", 8'(tx_endp), 8'd2);
    accept_tx(PID_IN, "t1_in_token");
    send_pid(PID_DATA0, 1'b0, 1'b0);
    rx_finish(1'b0);
    check_output("t1_ack_addr_held", 8'(tx_addr), 8'h08);
    check_output("t1_ack_endp_held", 8'(tx_endp), 8'd2);
    accept_tx(PID_ACK, "t1_in_ack");
    wait_drain();

    $display("[TB] second OUT uses DATA1, PID beats timeout");
    apply_stimulus(1'b0, K_OUT, 7'h08, 4'd1, ST_ACK);
    accept_tx(PID_OUT, "t2_token");
    send_dout(PID_DATA1, 1'b0);
    send_pid(PID_ACK, 1'b1, 1'b1);
    wait_drain();

    $display("[TB] repeated DATA0 on IN reports toggle skip");
    apply_stimulus(1'b1, K_IN, 7'h08, 4'd2, ST_SKIP);
    accept_tx(PID_IN, "t3_token");
    send_pid(PID_DATA0, 1'b0, 1'b0);
    rx_finish(1'b0);
    accept_tx(PID_ACK, "t3_ack");
    wait_drain();

    $display("[TB] OUT timing out on every attempt");
    apply_stimulus(1'b0, K_OUT, 7'h08, 4'd1, ST_ERR);
    for (int a = 0; a < TIMEOUT_ATTEMPTS; a++) begin
      accept_tx(PID_OUT, "t4_token");
      send_dout(PID_DATA0, 1'b0);
      send_timeout();
    end
    check_output("t4_err_latency", 8'(done_valid), 8'd1);
    quiet(4, "t4_extra_tokens");
    wait_drain();

    $display("[TB] IN with CRC error, then STALL");
`ifdef XACT_RETRY_EN
    apply_stimulus(1'b1, K_IN, 7'h08, 4'd2, ST_STALL);
    accept_tx(PID_IN, "t5_token");
    send_pid(PID_DATA1, 1'b0, 1'b0);
    rx_finish(1'b1);
    accept_tx(PID_IN, "t5_reissue");
    send_pid(PID_STALL, 1'b0, 1'b1);
`else
    apply_stimulus(1'b1, K_IN, 7'h08, 4'd2, ST_ERR);
    accept_tx(PID_IN, "t5_token");
    send_pid(PID_DATA1, 1'b0, 1'b0);
    rx_finish(1'b1);
    check_output("t5_err_latency", 8'(done_valid), 8'd1);
    quiet(3, "t5_no_ack");
    wait_drain();
    apply_stimulus(1'b1, K_IN, 7'h08, 4'd2, ST_STALL);
    accept_tx(PID_IN, "t5_token2");
    send_pid(PID_STALL, 1'b0, 1'b1);
`endif
    wait_drain();
    apply_stimulus(1'b1, K_IN, 7'h08, 4'd2, ST_ACK);
    accept_tx(PID_IN, "t5b_token");
    send_pid(PID_DATA1, 1'b0, 1'b0);
    rx_finish(1'b0);
    accept_tx(PID_ACK, "t5b_ack");
    wait_drain();

    $display("[TB] NAK keeps toggle, SETUP forces DATA0");
    apply_stimulus(1'b1, K_OUT, 7'h08, 4'd3, ST_NAK);
    accept_tx(PID_OUT, "nak_token");
    send_dout(PID_DATA0, 1'b1);
    send_pid(PID_NAK, 1'b0, 1'b1);
    wait_drain();
    apply_stimulus(1'b1, K_OUT, 7'h08, 4'd3, ST_ACK);
    accept_tx(PID_OUT, "nak_retry_token");
    send_dout(PID_DATA0, 1'b1);
    send_pid(PID_ACK, 1'b0, 1'b1);
    wait_drain();
    apply_stimulus(1'b1, K_SETUP, 7'h08, 4'd0, ST_ACK);
    accept_tx(PID_SETUP, "setup_token");
    send_dout(PID_DATA0, 1'b1);
    send_pid(PID_ACK, 1'b0, 1'b1);
    wait_drain();
    apply_stimulus(1'b1, K_OUT, 7'h08, 4'd0, ST_ACK);
    accept_tx(PID_OUT, "post_setup_token");
    send_dout(PID_DATA1, 1'b1);
    send_pid(PID_ACK, 1'b0, 1'b1);
    wait_drain();

    $display("[TB] reset during WAIT_DATA");
    apply_stimulus(1'b0, K_OUT, 7'h08, 4'd1, ST_ACK);
    accept_tx(PID_OUT, "t6_pre_token");
    send_dout(PID_DATA0, 1'b0);
    send_pid(PID_ACK, 1'b0, 1'b1);
    wait_drain();
    post_req(1'b0, K_IN, 7'h08, 4'd1);
    grant_wait(1'b0, 1'b1);
    accept_tx(PID_IN, "t6_in_token");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    apply_stimulus(1'b0, K_RSVD, 7'h08, 4'd1, ST_ACK);
    accept_tx(PID_OUT, "t6_reserved_token");
    send_dout(PID_DATA0, 1'b0);
    send_pid(PID_ACK, 1'b0, 1'b1);
    wait_drain();

    check_output("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
